// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer sitting between an enable-less Program_Counter and instruction memory:
// issues requests, holds fetched words for decode, and handles redirects and misaligned targets.
module pc_fetch_sequencer #(
  parameter int CHECK_ALIGN = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC_Cur,
  output logic [31:0] PC_Next,
  input  logic        Stall,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Rdata,
  output logic        Instr_Valid,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  input  logic        Instr_Ready,
  output logic        Misalign_Fault,
  output logic [31:0] Fetch_Count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]  state_r, state_n;
  logic [31:0] addr_q_r;
  logic [31:0] instr_r;
  logic [31:0] instr_pc_r;
  logic [31:0] fetch_count_r;
  logic        req_pending_r, req_pending_n;
  logic        fault_pending_r, fault_pending_n;

  logic [31:0] pc_next_s;
  logic        imem_req_s;
  logic [31:0] imem_addr_s;
  logic        instr_valid_s;
  logic        capture_s;
  logic        accept_s;
  logic        redir_bad_s;
  logic        fault_now_s;
  logic [31:0] target_s;

  function automatic logic is_misaligned(input logic [31:0] t);
    return (CHECK_ALIGN != 0) && (t[1:0] != 2'b00);
  endfunction

  // With alignment checking disabled the low target bits are simply dropped.
  function automatic logic [31:0] clean_target(input logic [31:0] t);
    return (CHECK_ALIGN != 0) ? t : {t[31:2], 2'b00};
  endfunction

  assign redir_bad_s = Redirect_Valid && is_misaligned(Redirect_Target);
  assign target_s    = clean_target(Redirect_Target);

  // Next-state, PC steering and memory-side outputs.
  always_comb begin
    state_n         = state_r;
    pc_next_s       = PC_Cur;
    imem_req_s      = 1'b0;
    imem_addr_s     = 32'd0;
    instr_valid_s   = 1'b0;
    capture_s       = 1'b0;
    accept_s        = 1'b0;
    req_pending_n   = 1'b0;
    fault_pending_n = fault_pending_r;
    fault_now_s     = fault_pending_r;
    case (state_r)
      S_IDLE: begin
        state_n = S_REQ;
      end
      S_REQ: begin
        imem_req_s  = req_pending_r | ~Stall;
        imem_addr_s = PC_Cur;
        if (Redirect_Valid) begin
          if (!redir_bad_s) begin
            pc_next_s = target_s;
          end else begin
            pc_next_s = PC_Cur;
          end
          // An unanswered request must still be drained before moving on.
          if (imem_req_s && !IMem_Ack) begin
            state_n         = S_DRAIN;
            fault_pending_n = redir_bad_s;
          end else if (redir_bad_s) begin
            state_n = S_FAULT;
          end else begin
            state_n = S_REQ;
          end
        end else if (imem_req_s && IMem_Ack) begin
          capture_s = 1'b1;
          state_n   = S_HOLD;
        end else if (imem_req_s) begin
          req_pending_n = 1'b1;
        end else begin
          state_n = S_REQ;
        end
      end
      S_DRAIN: begin
        imem_req_s  = 1'b1;
        imem_addr_s = addr_q_r;
        if (Redirect_Valid) begin
          fault_now_s = redir_bad_s;
          if (!redir_bad_s) begin
            pc_next_s = target_s;
          end else begin
            pc_next_s = PC_Cur;
          end
        end else begin
          fault_now_s = fault_pending_r;
        end
        if (IMem_Ack) begin
          state_n         = fault_now_s ? S_FAULT : S_REQ;
          fault_pending_n = 1'b0;
        end else begin
          fault_pending_n = fault_now_s;
        end
      end
      S_HOLD: begin
        instr_valid_s = ~Redirect_Valid;
        if (Redirect_Valid) begin
          if (redir_bad_s) begin
            state_n = S_FAULT;
          end else begin
            pc_next_s = target_s;
            state_n   = S_REQ;
          end
        end else if (Instr_Ready) begin
          pc_next_s = PC_Cur + 32'd4;
          accept_s  = 1'b1;
          state_n   = S_REQ;
        end else begin
          state_n = S_HOLD;
        end
      end
      S_FAULT: begin
        if (Redirect_Valid && !redir_bad_s) begin
          pc_next_s = target_s;
          state_n   = S_REQ;
        end else begin
          state_n = S_FAULT;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, captured instruction, request address and accepted-instruction counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r         <= S_IDLE;
      addr_q_r        <= 32'd0;
      instr_r         <= 32'd0;
      instr_pc_r      <= 32'd0;
      fetch_count_r   <= 32'd0;
      req_pending_r   <= 1'b0;
      fault_pending_r <= 1'b0;
    end else begin
      state_r         <= state_n;
      req_pending_r   <= req_pending_n;
      fault_pending_r <= fault_pending_n;
      if (state_r == S_REQ) begin
        addr_q_r <= PC_Cur;
      end
      if (capture_s) begin
        instr_r    <= IMem_Rdata;
        instr_pc_r <= PC_Cur;
      end
      if (accept_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end
    end
  end

  assign PC_Next        = pc_next_s;
  assign IMem_Req       = imem_req_s;
  assign IMem_Addr      = imem_addr_s;
  assign Instr_Valid    = instr_valid_s;
  assign Instr          = instr_r;
  assign Instr_PC       = instr_pc_r;
  assign Misalign_Fault = (state_r == S_FAULT);
  assign Fetch_Count    = fetch_count_r;

endmodule
